// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - opcodes, state/class enums and ALU encodings for the RV32I multi-cycle sequencer
package rv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALU_DST_ALU = 2'b00;
  localparam logic [1:0] ALU_DST_MEM = 2'b01;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } rv_mc_state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
  } rv_inst_class_e;

endpackage

// File: rtl/rv_mc_decode.sv
// rtl/rv_mc_decode.sv - opcode to instruction class plus the static per-class ALU controls
module rv_mc_decode
  import rv_pkg::*;
(
  input  logic [6:0]     opcode_i,
  output rv_inst_class_e class_o,
  output logic [1:0]     alu_op_o,
  output logic           alu_src_o
);

  always_comb begin
    class_o   = CLS_ILLEGAL;
    alu_op_o  = ALU_OP_ADD;
    alu_src_o = 1'b0;
    case (opcode_i)
      OPC_R: begin
        class_o  = CLS_R;
        alu_op_o = ALU_OP_FUNCT;
      end
      OPC_I: begin
        class_o   = CLS_I;
        alu_op_o  = ALU_OP_FUNCT;
        alu_src_o = 1'b1;
      end
      OPC_LOAD: begin
        class_o   = CLS_LOAD;
        alu_src_o = 1'b1;
      end
      OPC_STORE: begin
        class_o   = CLS_STORE;
        alu_src_o = 1'b1;
      end
      OPC_BRANCH: begin
        class_o  = CLS_BRANCH;
        alu_op_o = ALU_OP_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// rtl/rv_mc_ctrl.sv - multi-cycle RV32I control FSM with memory handshake timeout
// Build option RV_MC_ILLEGAL_TRAP_EN: trap unsupported opcodes into HALT instead of retiring them as NOPs.
module rv_mc_ctrl
  import rv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       mem_addr_sel_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       pc_src_o,
  output logic [1:0] alu_op_o,
  output logic       alu_src_o,
  output logic [1:0] alu_dst_o,
  output logic       rd_we_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic       bus_err_o
);

  localparam int          CNT_W   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [31:0] TMO     = 32'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rv_mc_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             berr_q, berr_d;
  rv_inst_class_e   cls;
  logic [1:0]       dec_alu_op;
  logic             dec_alu_src;
  logic             mem_phase;
  logic             timeout;

  rv_mc_decode u_decode (
    .opcode_i  (opcode_i),
    .class_o   (cls),
    .alu_op_o  (dec_alu_op),
    .alu_src_o (dec_alu_src)
  );

  assign mem_phase = (state_q == ST_FETCH) || (state_q == ST_MEM);
  // Firing on the last allowed wait cycle keeps the request up for exactly MEM_TIMEOUT cycles.
  assign timeout   = mem_phase && !mem_ack_i && (TMO != 32'd0) && ((32'(cnt_q) + 32'd1) >= TMO);

`ifdef RV_MC_ILLEGAL_TRAP_EN
  logic ill_q, ill_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) ill_q <= 1'b0;
    else       ill_q <= ill_d;
  end

  assign illegal_o = ill_q & ~rst_i;
`else
  assign illegal_o = 1'b0;
`endif

  assign bus_err_o = berr_q & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    berr_d         = berr_q;
`ifdef RV_MC_ILLEGAL_TRAP_EN
    ill_d          = ill_q;
`endif
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_src_o       = 1'b0;
    alu_op_o       = ALU_OP_ADD;
    alu_src_o      = 1'b0;
    alu_dst_o      = ALU_DST_ALU;
    rd_we_o        = 1'b0;
    retire_o       = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          berr_d  = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (cls == CLS_ILLEGAL) begin
`ifdef RV_MC_ILLEGAL_TRAP_EN
          ill_d   = 1'b1;
          state_d = ST_HALT;
`else
          retire_o = 1'b1;
          state_d  = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op_o  = dec_alu_op;
        alu_src_o = dec_alu_src;
        case (cls)
          CLS_R, CLS_I:         state_d = ST_WB;
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          CLS_BRANCH: begin
            pc_we_o  = branch_taken_i;
            pc_src_o = 1'b1;
            retire_o = 1'b1;
            state_d  = ST_FETCH;
          end
          default:              state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = (cls == CLS_STORE);
        if (mem_ack_i) begin
          if (cls == CLS_STORE) begin
            retire_o = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          berr_d  = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_WB: begin
        rd_we_o   = 1'b1;
        retire_o  = 1'b1;
        alu_dst_o = (cls == CLS_LOAD) ? ALU_DST_MEM : ALU_DST_ALU;
        state_d   = ST_FETCH;
      end
      default: ;
    endcase

    if (mem_phase && !mem_ack_i && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) cnt_d = '0;

    // Reset dominates every output, including a request already in flight.
    if (rst_i) begin
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_sel_o = 1'b0;
      ir_we_o        = 1'b0;
      pc_we_o        = 1'b0;
      pc_src_o       = 1'b0;
      alu_op_o       = ALU_OP_ADD;
      alu_src_o      = 1'b0;
      alu_dst_o      = ALU_DST_ALU;
      rd_we_o        = 1'b0;
      retire_o       = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// tb/tb_rv_mc_ctrl.sv - randomized instruction-level bench for rv_mc_ctrl with a per-cycle output model
module tb_rv_mc_ctrl;

  localparam int TMO = 4;

  localparam logic [14:0] B_REQ   = 15'h4000;
  localparam logic [14:0] B_WE    = 15'h2000;
  localparam logic [14:0] B_AS    = 15'h1000;
  localparam logic [14:0] B_IR    = 15'h0800;
  localparam logic [14:0] B_PCWE  = 15'h0400;
  localparam logic [14:0] B_PCSRC = 15'h0200;
  localparam logic [14:0] OP_FN   = 15'h0100;
  localparam logic [14:0] OP_SUB  = 15'h0080;
  localparam logic [14:0] B_SRC   = 15'h0040;
  localparam logic [14:0] DST_MEM = 15'h0010;
  localparam logic [14:0] B_RD    = 15'h0008;
  localparam logic [14:0] B_RET   = 15'h0004;
  localparam logic [14:0] B_ILL   = 15'h0002;
  localparam logic [14:0] B_BERR  = 15'h0001;

  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, OPLD = 7'b0000011;
  localparam logic [6:0] OPST = 7'b0100011, OPBR = 7'b1100011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i = 1'b1;
  logic [6:0] ir = 7'd0;
  logic       taken = 1'b0, ack = 1'b0;
  logic       mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o, pc_src_o;
  logic [1:0] alu_op_o, alu_dst_o;
  logic       alu_src_o, rd_we_o, retire_o, illegal_o, bus_err_o;

  rv_mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .opcode_i(ir), .branch_taken_i(taken), .mem_ack_i(ack),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_sel_o(mem_addr_sel_o),
    .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o), .alu_op_o(alu_op_o),
    .alu_src_o(alu_src_o), .alu_dst_o(alu_dst_o), .rd_we_o(rd_we_o), .retire_o(retire_o),
    .illegal_o(illegal_o), .bus_err_o(bus_err_o)
  );

  logic [14:0] outv;
  assign outv = {mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o, pc_src_o, alu_op_o,
                 alu_src_o, alu_dst_o, rd_we_o, retire_o, illegal_o, bus_err_o};

  int          errors = 0, checks = 0, cyc_n = 0, last_ret = -1;
  logic [14:0] exp_v = 15'h0;
  bit          exp_on = 1'b0, m_ill = 1'b0, m_berr = 1'b0;
  logic        s_req = 1'b0, s_berr = 1'b0, s_ill = 1'b0;

  always @(negedge clk) begin
    if (exp_on) begin
      checks++;
      if (outv !== exp_v) begin
        errors++;
        $display("FAIL cycle %0d outputs: got %04h expected %04h", cyc_n, outv, exp_v);
      end
      if (retire_o === 1'b1) last_ret = cyc_n;
      s_req  = mem_req_o;
      s_berr = bus_err_o;
      s_ill  = illegal_o;
    end
  end

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic int classify(input logic [6:0] op);
    case (op)
      OPR:     return 0;
      OPI:     return 1;
      OPLD:    return 2;
      OPST:    return 3;
      OPBR:    return 4;
      default: return 5;
    endcase
  endfunction

  task automatic lit(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // One clock: drive inputs, publish the expected outputs, advance past the edge.
  task automatic cyc(input logic [14:0] e, input bit a, input bit tk, input bit r);
    ack    = a;
    taken  = tk;
    rst_i  = r;
    exp_v  = r ? 15'h0 : (e | (m_ill ? B_ILL : 15'h0) | (m_berr ? B_BERR : 15'h0));
    exp_on = 1'b1;
    @(posedge clk);
    #1;
    cyc_n++;
    if (r) begin
      m_ill  = 1'b0;
      m_berr = 1'b0;
    end
  endtask

  // st: 0 acked, 1 timed out (now halted), 2 reset abandoned the request
  task automatic mem_phase(input logic [14:0] base, input logic [14:0] on_ack, input int w,
                           input int rst_at, output int st);
    st = 0;
    for (int i = 0; i <= w + TMO; i++) begin
      if (i == rst_at) begin
        cyc(15'h0, rb(), rb(), 1'b1);
        st = 2;
        return;
      end
      if (i == w) begin
        cyc(base | on_ack, 1'b1, rb(), 1'b0);
        return;
      end
      cyc(base, 1'b0, rb(), 1'b0);
      if (i + 1 >= TMO) begin
        m_berr = 1'b1;
        st = 1;
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit tk,
                           input int rst_at, output int st);
    int cls;
    mem_phase(B_REQ, B_IR | B_PCWE, fw, -1, st);
    if (st != 0) return;
    ir  = op;
    cls = classify(op);
    if (cls == 5) begin
`ifdef RV_MC_ILLEGAL_TRAP_EN
      cyc(15'h0, rb(), rb(), 1'b0);
      m_ill = 1'b1;
      st = 1;
`else
      cyc(B_RET, rb(), rb(), 1'b0);
`endif
      return;
    end
    cyc(15'h0, rb(), rb(), 1'b0);
    case (cls)
      0:       cyc(OP_FN, rb(), rb(), 1'b0);
      1:       cyc(OP_FN | B_SRC, rb(), rb(), 1'b0);
      2, 3:    cyc(B_SRC, rb(), rb(), 1'b0);
      default: begin
        cyc(OP_SUB | B_PCSRC | B_RET | (tk ? B_PCWE : 15'h0), rb(), tk, 1'b0);
        return;
      end
    endcase
    if (cls == 2 || cls == 3) begin
      mem_phase(B_REQ | B_AS | ((cls == 3) ? B_WE : 15'h0), (cls == 3) ? B_RET : 15'h0,
                mw, rst_at, st);
      if (st != 0 || cls == 3) return;
    end
    cyc(B_RD | B_RET | ((cls == 2) ? DST_MEM : 15'h0), rb(), rb(), 1'b0);
  endtask

  task automatic halt_cycles();
    repeat (3) cyc(15'h0, rb(), rb(), 1'b0);
  endtask

  task automatic reset_cycle();
    cyc(15'h0, rb(), rb(), 1'b1);
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom % 16);
    return (r == 0) ? TMO + 2 : r % 4;
  endfunction

  initial begin
    int s0, st, prev, k, fw, mw, ra;
    logic [6:0] op;
    @(posedge clk);
    #1;
    cyc(15'h0, 1'b0, 1'b0, 1'b1);
    cyc(15'h0, 1'b1, 1'b1, 1'b1);
    lit("req during reset", int'(s_req), 0);

    s0 = cyc_n; run_instr(OPR, 0, 0, 1'b0, -1, st);  lit("add cycles", last_ret - s0 + 1, 4);
    s0 = cyc_n; run_instr(OPLD, 0, 2, 1'b0, -1, st); lit("lw 2-wait cycles", last_ret - s0 + 1, 7);
    s0 = cyc_n; run_instr(OPBR, 0, 0, 1'b1, -1, st); lit("beq taken cycles", last_ret - s0 + 1, 3);
    s0 = cyc_n; run_instr(OPBR, 0, 0, 1'b0, -1, st); lit("beq not-taken cycles", last_ret - s0 + 1, 3);
    s0 = cyc_n; run_instr(OPST, 0, 0, 1'b0, -1, st); lit("sw cycles", last_ret - s0 + 1, 4);
    s0 = cyc_n; run_instr(OPLD, 0, 0, 1'b0, -1, st); lit("lw cycles", last_ret - s0 + 1, 5);
    s0 = cyc_n; run_instr(OPI, TMO - 1, 0, 1'b0, -1, st);
    lit("ack on last timeout cycle", last_ret - s0 + 1, 4 + TMO - 1);
    s0 = cyc_n; run_instr(OPST, 3, 3, 1'b0, -1, st); lit("sw fetch3 mem3 cycles", last_ret - s0 + 1, 10);

    s0 = cyc_n; run_instr(7'b1111111, 0, 0, 1'b0, -1, st);
`ifdef RV_MC_ILLEGAL_TRAP_EN
    halt_cycles();
    lit("illegal sticky", int'(s_ill), 1);
    lit("illegal halt req", int'(s_req), 0);
    reset_cycle();
`else
    lit("illegal nop cycles", last_ret - s0 + 1, 2);
`endif

    run_instr(OPR, TMO + 3, 0, 1'b0, -1, st);
    lit("timeout status", st, 1);
    halt_cycles();
    lit("bus_err sticky", int'(s_berr), 1);
    lit("halt req", int'(s_req), 0);
    reset_cycle();

    prev = last_ret;
    run_instr(OPST, 0, 5, 1'b0, 2, st);
    lit("sw reset status", st, 2);
    lit("no retire on reset", last_ret, prev);
    s0 = cyc_n; run_instr(OPR, 0, 0, 1'b0, -1, st); lit("add after reset cycles", last_ret - s0 + 1, 4);

    for (int n = 0; n < 300; n++) begin
      k = int'($urandom % 8);
      case (k)
        0, 7:    op = OPR;
        1:       op = OPI;
        2:       op = OPLD;
        3:       op = OPST;
        4, 5:    op = OPBR;
        default: begin
          op = 7'($urandom);
          while (classify(op) != 5) op = 7'($urandom);
        end
      endcase
      fw = rand_wait();
      mw = rand_wait();
      ra = ($urandom % 20 == 0) ? int'($urandom % 3) : -1;
      run_instr(op, fw, mw, rb(), ra, st);
      if (st == 1) begin
        halt_cycles();
        reset_cycle();
      end
    end

    exp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
